// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiplier and restoring signed divider for M-type ops
// Ports: clk/rst (async active-high), start+alu_control+op_a+op_b request an op, flush aborts,
// busy/stall/done report progress, result holds product/quotient/remainder until overwritten.
// Build option: define MULDIV_FAST_PATH_EN to finish div-by-zero, signed overflow and mul-by-zero in one cycle.
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t r_state, w_next;
   logic [5:0]      r_cnt;
   logic [XLEN-1:0] r_op_a, r_op_b, r_x, r_y, r_z, r_result;
   logic            r_rem;
   logic            w_is_m, w_is_mul, w_accept, w_last, w_fast, w_ge;
   logic [XLEN-1:0] w_fast_res, w_abs_a, w_abs_b, w_mul_x, w_rem_n, w_quo_n, w_q, w_r, w_iter_res;
   logic [XLEN:0]   w_sh;
   assign w_is_m   = alu_control inside {4'b1011, 4'b1100, 4'b1101};
   assign w_is_mul = alu_control == 4'b1011;
   assign w_accept = r_state == IDLE && start && w_is_m && !flush;
   assign w_last   = (r_state == MUL || r_state == DIV) && r_cnt == 6'(XLEN-1);
   assign w_abs_a  = op_a[XLEN-1] ? -op_a : op_a;
   assign w_abs_b  = op_b[XLEN-1] ? -op_b : op_b;
`ifdef MULDIV_FAST_PATH_EN
   assign w_fast = w_is_mul ? (op_a == '0 || op_b == '0)
                            : (op_b == '0 || (op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1));
   assign w_fast_res = w_is_mul ? '0 :
                       op_b == '0 ? (alu_control == 4'b1100 ? '1 : op_a) :
                       (alu_control == 4'b1100 ? op_a : '0);
`else
   assign w_fast     = 1'b0;
   assign w_fast_res = '0;
`endif
   // multiply: r_x accumulates, r_y is the left-shifting multiplicand, r_z the right-shifting multiplier
   assign w_mul_x = r_x + (r_z[0] ? r_y : '0);
   // divide: {r_x, r_y} is the remainder/quotient pair; r_z holds the divisor magnitude.
   // The partial remainder always stays below the divisor (or equals a prefix of |a| when dividing by zero),
   // so XLEN bits are enough to keep it.
   assign w_sh    = {r_x, r_y[XLEN-1]};
   assign w_ge    = w_sh >= {1'b0, r_z};
   assign w_rem_n = w_ge ? XLEN'(w_sh - {1'b0, r_z}) : w_sh[XLEN-1:0];
   assign w_quo_n = {r_y[XLEN-2:0], w_ge};
   assign w_q     = (r_op_a[XLEN-1] ^ r_op_b[XLEN-1]) ? -w_quo_n : w_quo_n;
   assign w_r     = r_op_a[XLEN-1] ? -w_rem_n : w_rem_n;
   // the overflow case falls out of the magnitude algorithm; only divide-by-zero needs an override
   assign w_iter_res = r_state == MUL ? w_mul_x :
                       r_op_b == '0 ? (r_rem ? r_op_a : '1) :
                       r_rem ? w_r : w_q;
   assign result = r_result;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      busy   = r_state != IDLE;
      stall  = !rst && ((r_state == IDLE && start && w_is_m) || r_state == MUL || r_state == DIV);
      done   = r_state == DONE && !flush;
      unique case (r_state)
         IDLE:     if (w_accept) w_next = w_fast ? DONE : w_is_mul ? MUL : DIV;
         MUL, DIV: w_next = flush ? IDLE : w_last ? DONE : r_state;
         default:  w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_rem    <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_z      <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_op_a <= op_a;
            r_op_b <= op_b;
            r_rem  <= alu_control == 4'b1101;
            r_cnt  <= '0;
            r_x    <= '0;
            r_y    <= w_is_mul ? op_a : w_abs_a;
            r_z    <= w_is_mul ? op_b : w_abs_b;
         end else if (r_state == MUL || r_state == DIV) begin
            r_cnt <= (flush || w_last) ? '0 : r_cnt + 6'd1;
            r_x   <= r_state == MUL ? w_mul_x : w_rem_n;
            r_y   <= r_state == MUL ? r_y << 1 : w_quo_n;
            r_z   <= r_state == MUL ? r_z >> 1 : r_z;
         end
         if (w_accept && w_fast) r_result <= w_fast_res;
         else if (w_last && !flush) r_result <= w_iter_res;
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: vector table, corner sequences and random ops against a signed-arithmetic model
module tb_muldiv_sequencer;
   localparam logic [3:0] OP_MUL = 4'b1011, OP_DIV = 4'b1100, OP_REM = 4'b1101;
   logic        clk = 0, rst = 1, start = 0, flush = 0;
   logic [3:0]  alu_control = 0;
   logic [31:0] op_a = 0, op_b = 0;
   logic        busy, stall, done;
   logic [31:0] result;
   int checks = 0, errors = 0;
   typedef struct {
      logic [3:0]  c;
      logic [31:0] a, b, exp;
   } vec_t;
   vec_t tbl[16];
   always #5 clk = ~clk;
   muldiv_sequencer #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
      .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (c == OP_MUL) begin
         p = 64'(sa * sb);
         return p[31:0];
      end
      if (b == 0) return c == OP_DIV ? 32'hFFFF_FFFF : a;
      p = 64'(c == OP_DIV ? sa / sb : sa % sb);
      return p[31:0];
   endfunction
   function automatic int ref_lat(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_PATH_EN
      if (c == OP_MUL && (a == 0 || b == 0)) return 1;
      if (c != OP_MUL && (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`endif
      return 33;
   endfunction
   // drives one accept and returns the result and the number of cycles from accept to done
   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input bit hold,
                         output logic [31:0] res, output int lat);
      bit bad;
      @(negedge clk);
      chk("idle_before_accept", {30'd0, busy, done}, 32'd0);
      start = 1; alu_control = c; op_a = a; op_b = b;
      #1 chk("stall_on_accept", {31'd0, stall}, 32'd1);
      @(negedge clk);
      lat = 1; bad = 0;
      start = hold; alu_control = OP_MUL; op_a = 9; op_b = 9;
      while (!done && lat < 80) begin
         if (!stall || !busy) bad = 1;
         @(negedge clk);
         lat++;
         if (lat >= 20) start = 0;
      end
      start = 0;
      chk("stall_busy_while_running", {31'd0, bad}, 32'd0);
      chk("stall_low_in_done", {31'd0, stall}, 32'd0);
      res = result;
   endtask
   task automatic op_check(input string name, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit hold);
      logic [31:0] res;
      int lat;
      run_op(c, a, b, hold, res, lat);
      chk({name, "_result"}, res, exp);
      chk({name, "_latency"}, lat, ref_lat(c, a, b));
   endtask
   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(20));
         default: return $urandom;
      endcase
   endfunction
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [31:0] prev, a, b;
      logic [3:0] c;
      bit seen;
      tbl[0]  = '{OP_MUL, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      tbl[1]  = '{OP_DIV, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFA};
      tbl[2]  = '{OP_REM, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFE};
      tbl[3]  = '{OP_DIV, 32'd5,          32'd0,          32'hFFFF_FFFF};
      tbl[4]  = '{OP_REM, 32'd5,          32'd0,          32'd5};
      tbl[5]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      tbl[6]  = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
      tbl[7]  = '{OP_MUL, 32'd0,          32'd12345,      32'd0};
      tbl[8]  = '{OP_DIV, 32'd100,        32'd7,          32'd14};
      tbl[9]  = '{OP_REM, 32'd100,        32'd7,          32'd2};
      tbl[10] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
      tbl[11] = '{OP_REM, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
      tbl[12] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
      tbl[13] = '{OP_DIV, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};
      tbl[14] = '{OP_DIV, 32'hFFFF_FFF6, 32'd0,          32'hFFFF_FFFF};
      tbl[15] = '{OP_REM, 32'hFFFF_FFF6, 32'd0,          32'hFFFF_FFF6};
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      @(posedge clk);
      #2 rst = 0;
      for (int i = 0; i < 16; i++) op_check($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);
      // non-M code in IDLE is ignored
      @(negedge clk);
      start = 1; alu_control = 4'b0000; op_a = 3; op_b = 4;
      #1 chk("nonm_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      start = 0;
      chk("nonm_busy", {31'd0, busy}, 32'd0);
      // start held high while busy must not disturb the running divide
      op_check("start_while_busy", OP_DIV, 32'd1000, 32'd7, 32'd142, 1'b1);
      // flush in the middle of a divide
      prev = result;
      @(negedge clk);
      start = 1; alu_control = OP_DIV; op_a = 100; op_b = 7;
      seen = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         start = 0;
         if (done) seen = 1;
      end
      flush = 1;
      @(negedge clk);
      flush = 0;
      if (done) seen = 1;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_no_done", {31'd0, seen}, 32'd0);
      chk("flush_result_kept", result, prev);
      op_check("after_flush", OP_REM, 32'd100, 32'd7, 32'd2, 1'b0);
      // flush together with start in IDLE: no accept
      @(negedge clk);
      start = 1; flush = 1; alu_control = OP_DIV; op_a = 50; op_b = 3;
      @(negedge clk);
      start = 0; flush = 0;
      chk("flush_start_idle", {31'd0, busy}, 32'd0);
      // reset in the middle of a multiply
      @(negedge clk);
      start = 1; alu_control = OP_MUL; op_a = 3; op_b = 5;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      start = 1;
      #2 rst = 1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_stall", {31'd0, stall}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_result", result, 32'd0);
      start = 0;
      @(posedge clk);
      #2 rst = 0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      chk("midrst_no_done_after", {31'd0, seen}, 32'd0);
      // randomized ops against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(2))
            0: c = OP_MUL;
            1: c = OP_DIV;
            default: c = OP_REM;
         endcase
         a = rnd_operand();
         b = rnd_operand();
         op_check($sformatf("rand%0d_op%h_%h_%h", i, c, a, b), c, a, b, ref_res(c, a, b), 1'b0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
